// File: rtl/eight_bit_sequential_divider.sv
// Unsigned restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Valid/ready on both sides; divide-by-zero and quotient overflow are flagged without iterating.
module eight_bit_sequential_divider #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Trial value: partial remainder shifted left with the next dividend bit.
  // When t >= divisor the difference fits W bits, so the carry-out is dropped.
  assign t    = {r_q, lo_q[WIDTH-1]};
  assign ge   = (t >= {1'b0, dvs_q});
  assign diff = t[WIDTH-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          lo_d  = dividend[WIDTH-1:0];
          cnt_d = '0;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            q_d     = '1;
            r_d     = '0;
            state_d = S_DONE;
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            ovf_d   = 1'b1;
            q_d     = '1;
            r_d     = '0;
            state_d = S_DONE;
          end else begin
            q_d     = '0;
            r_d     = dividend[2*WIDTH-1:WIDTH];
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        r_d   = ge ? diff : t[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ge};
        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_eight_bit_sequential_divider.sv
// Scoreboard bench for the sequential divider: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_eight_bit_sequential_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  eight_bit_sequential_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Output monitor: compare whenever a handshake will complete on the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: q=0x%0h r=0x%0h with empty scoreboard", quotient, remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        chk("overflow", 32'(overflow), 32'(e.ov));
      end
    end
  end

  // No overlap of input and output sides.
  always @(negedge clk) begin
    if (rst_n) chk("ready_valid_overlap", 32'(in_ready && out_valid), 32'd0);
  end

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    logic [7:0] hi;
    hi = a[15:8];
    if (b == 8'd0)    e = '{q: 8'hFF, r: 8'h00, dz: 1'b1, ov: 1'b0};
    else if (hi >= b) e = '{q: 8'hFF, r: 8'h00, dz: 1'b0, ov: 1'b1};
    else              e = '{q: 8'(a / 16'(b)), r: 8'(a % 16'(b)), dz: 1'b0, ov: 1'b0};
    return e;
  endfunction

  // Present operands (called #1 after a posedge) and wait for the accept edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit push, input exp_t e);
    int n;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        return;
      end
    end
    @(posedge clk);
    if (push) sb.push_back(e);
    #1;
  endtask

  // Cycles from accept edge until out_valid is seen; leaves us at a negedge.
  task automatic wait_valid(output int k);
    k = 1;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      k++;
      if (k > 50) begin
        checks++;
        errors++;
        $display("FAIL valid_timeout: out_valid missing after %0d cycles", k);
        return;
      end
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input exp_t e, input int lat);
    int k;
    issue(a, b, 1'b1, e);
    in_valid = 1'b0;
    wait_valid(k);
    chk("latency", 32'(k), 32'(lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int   n;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with hand-computed results.
    run_op(16'h3039, 8'h64, '{q: 8'h7B, r: 8'h2D, dz: 1'b0, ov: 1'b0}, 9);
    run_op(16'h1234, 8'h00, '{q: 8'hFF, r: 8'h00, dz: 1'b1, ov: 1'b0}, 1);
    run_op(16'h6400, 8'h64, '{q: 8'hFF, r: 8'h00, dz: 1'b0, ov: 1'b1}, 1);
    run_op(16'h63FF, 8'h64, '{q: 8'hFF, r: 8'h63, dz: 1'b0, ov: 1'b0}, 9);
    run_op(16'h00FF, 8'h01, '{q: 8'hFF, r: 8'h00, dz: 1'b0, ov: 1'b0}, 9);
    run_op(16'h0007, 8'h03, '{q: 8'h02, r: 8'h01, dz: 1'b0, ov: 1'b0}, 9);
    run_op(16'h0000, 8'hFF, '{q: 8'h00, r: 8'h00, dz: 1'b0, ov: 1'b0}, 9);

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(16'h3039, 8'h64, 1'b1, '{q: 8'h7B, r: 8'h2D, dz: 1'b0, ov: 1'b0});
    in_valid = 1'b1;
    dividend = 16'h1111; divisor = 8'h22;
    begin
      int k;
      wait_valid(k);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_q", 32'(quotient), 32'h7B);
      chk("hold_r", 32'(remainder), 32'h2D);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Reset during iteration 4 aborts the op with no result.
    issue(16'h3039, 8'h64, 1'b0, '0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_outputs", 32'({quotient, remainder, div_by_zero, overflow}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'hFE01, 8'hFF, '{q: 8'hFF, r: 8'h00, dz: 1'b0, ov: 1'b0}, 9);

    // Random back-to-back traffic; in_valid stays high while the block is busy.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      b = 8'($urandom_range(0, 255));
      if (i % 8 == 0) b = 8'd0;
      a = 16'($urandom);
      if (b != 0 && (i % 4 != 0)) a = 16'($urandom_range(0, (32'(b) << 8) - 1));
      issue(a, b, 1'b1, model(a, b));
    end
    in_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
